// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: computes diff = a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell whose borrow-out is registered and fed back.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    // Shared full-subtractor cell
    logic d_bit, b_bit;
    always_comb begin
        d_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        b_bit = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                end
            end
            StShift: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = b_bit;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    bout_d  = b_bit;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
